// File: rtl/bounce_box_renderer.sv
// bounce_box_renderer
//   Pixel source for the HDMI controller. A square box moves STEP pixels per
//   axis once per frame and bounces off the edges of the active area, drawn
//   over a fixed background. Blanking is black. The box colour advances
//   through a 4-entry palette on every frame in which a bounce occurs.
//
// Ports:
//   pixelClk  - pixel clock (only clock)
//   reset     - synchronous, active-low reset
//   enable    - 1 = motion enabled, 0 = position frozen
//   screenX   - current scan column from the controller
//   screenY   - current scan line from the controller
//   vgaRed    - red channel, 2 cycles after screenX/screenY
//   vgaGreen  - green channel
//   vgaBlue   - blue channel
//   frameTick - one-cycle pulse at start of vertical blank
module bounce_box_renderer #(
    parameter int          H_ACTIVE = 640,
    parameter int          V_ACTIVE = 480,
    parameter int          BOX_SIZE = 64,
    parameter int          STEP     = 2,
    parameter logic [23:0] BG_COLOR = 24'h113355
) (
    input  logic       pixelClk,
    input  logic       reset,
    input  logic       enable,
    input  logic [9:0] screenX,
    input  logic [9:0] screenY,
    output logic [7:0] vgaRed,
    output logic [7:0] vgaGreen,
    output logic [7:0] vgaBlue,
    output logic       frameTick
);

    typedef enum logic {DIR_POS, DIR_NEG} dir_t;

    typedef struct packed {
        logic        hit;
        dir_t        dir;
        logic [10:0] pos;
    } axis_t;

    localparam logic [10:0] H_W    = 11'(H_ACTIVE);
    localparam logic [9:0]  V_LINE = 10'(V_ACTIVE);
    localparam logic [10:0] V_W    = 11'(V_ACTIVE);
    localparam logic [10:0] SIZE_W = 11'(BOX_SIZE);
    localparam logic [10:0] STEP_W = 11'(STEP);
    localparam logic [10:0] LIM_X  = 11'(H_ACTIVE - BOX_SIZE);
    localparam logic [10:0] LIM_Y  = 11'(V_ACTIVE - BOX_SIZE);
    localparam logic [10:0] X0     = 11'((H_ACTIVE - BOX_SIZE) / 2);
    localparam logic [10:0] Y0     = 11'((V_ACTIVE - BOX_SIZE) / 2);

    logic [10:0] boxX, boxY;
    dir_t        dirX, dirY;
    logic [1:0]  hitCount;
    logic        condPrev;
    logic        activeS1, inBoxS1;
    logic [23:0] colourS2;

    logic        cond, tick;
    logic        activeNext, inBoxNext;
    logic [23:0] colourNext;
    axis_t       axisX, axisY;
    logic [10:0] sx, sy;

    // One axis of motion: advance by STEP, clamping to the wall and
    // reversing direction when the wall is reached.
    function automatic axis_t stepAxis(input logic [10:0] pos, input dir_t dir,
                                       input logic [10:0] lim);
        axis_t r;
        r.hit = 1'b0;
        r.dir = dir;
        r.pos = pos;
        if (dir == DIR_POS) begin
            if (pos + STEP_W >= lim) begin
                r.pos = lim;
                r.dir = DIR_NEG;
                r.hit = 1'b1;
            end else begin
                r.pos = pos + STEP_W;
            end
        end else begin
            if (pos <= STEP_W) begin
                r.pos = '0;
                r.dir = DIR_POS;
                r.hit = 1'b1;
            end else begin
                r.pos = pos - STEP_W;
            end
        end
        return r;
    endfunction

    always_comb begin
        sx         = {1'b0, screenX};
        sy         = {1'b0, screenY};
        cond       = (screenX == '0) && (screenY == V_LINE);
        tick       = cond && !condPrev;
        axisX      = stepAxis(boxX, dirX, LIM_X);
        axisY      = stepAxis(boxY, dirY, LIM_Y);
        activeNext = (sx < H_W) && (sy < V_W);
        inBoxNext  = (sx >= boxX) && (sx < boxX + SIZE_W) &&
                     (sy >= boxY) && (sy < boxY + SIZE_W);
        colourNext = BG_COLOR;
        if (!activeS1) begin
            colourNext = '0;
        end else if (inBoxS1) begin
            case (hitCount)
                2'd0:    colourNext = 24'hFFFFFF;
                2'd1:    colourNext = 24'hFF2020;
                2'd2:    colourNext = 24'h20FF20;
                default: colourNext = 24'h2020FF;
            endcase
        end
    end

    always_ff @(posedge pixelClk) begin
        if (!reset) begin
            boxX      <= X0;
            boxY      <= Y0;
            dirX      <= DIR_POS;
            dirY      <= DIR_POS;
            hitCount  <= '0;
            condPrev  <= 1'b0;
            frameTick <= 1'b0;
            activeS1  <= 1'b0;
            inBoxS1   <= 1'b0;
            colourS2  <= '0;
        end else begin
            condPrev  <= cond;
            frameTick <= tick;
            if (tick && enable) begin
                boxX <= axisX.pos;
                dirX <= axisX.dir;
                boxY <= axisY.pos;
                dirY <= axisY.dir;
                // A corner hit counts as a single bounce.
                if (axisX.hit || axisY.hit)
                    hitCount <= hitCount + 2'd1;
            end
            activeS1 <= activeNext;
            inBoxS1  <= inBoxNext;
            colourS2 <= colourNext;
        end
    end

    assign vgaRed   = colourS2[23:16];
    assign vgaGreen = colourS2[15:8];
    assign vgaBlue  = colourS2[7:0];

endmodule

// File: tb/tb_bounce_box_renderer.sv
// tb_bounce_box_renderer
//   Drives scan coordinates one per cycle and compares the colour stream and
//   frameTick against a behavioural model of the bouncing box.
module tb_bounce_box_renderer;

    localparam int H = 640;
    localparam int V = 480;
    localparam int BOX = 64;
    localparam int STEP = 2;
    localparam logic [23:0] BG = 24'h113355;

    logic       pixelClk;
    logic       reset;
    logic       enable;
    logic [9:0] screenX;
    logic [9:0] screenY;
    logic [7:0] vgaRed, vgaGreen, vgaBlue;
    logic       frameTick;

    bounce_box_renderer dut (
        .pixelClk (pixelClk),
        .reset    (reset),
        .enable   (enable),
        .screenX  (screenX),
        .screenY  (screenY),
        .vgaRed   (vgaRed),
        .vgaGreen (vgaGreen),
        .vgaBlue  (vgaBlue),
        .frameTick(frameTick)
    );

    initial pixelClk = 1'b0;
    always #5 pixelClk = ~pixelClk;

    int compared = 0;
    int mismatched = 0;

    // Model state: box origin, signed direction per axis, bounce count.
    int bx, by, dx, dy, hc;
    bit prevCond;
    logic [23:0] pal [4];

    // Expectation pipeline: pipe0 is for the input driven last cycle,
    // pipe1 for the one before (the one on the outputs now).
    logic [23:0] pipe0, pipe1;
    bit          pipeV0, pipeV1;
    bit          tickExp;

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        compared++;
        if (got !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic modelReset();
        bx = (H - BOX) / 2;
        by = (V - BOX) / 2;
        dx = 1;
        dy = 1;
        hc = 0;
        prevCond = 1'b0;
    endtask

    task automatic moveAxis(inout int p, inout int d, input int lim, output bit hit);
        hit = 1'b0;
        p = p + d * STEP;
        if (p >= lim) begin
            p = lim; d = -1; hit = 1'b1;
        end else if (p <= 0) begin
            p = 0; d = 1; hit = 1'b1;
        end
    endtask

    function automatic logic [23:0] expColour(input int x, input int y);
        if (!(x < H && y < V)) return 24'h000000;
        if (x >= bx && x < bx + BOX && y >= by && y < by + BOX) return pal[hc];
        return BG;
    endfunction

    // One pixel clock: check what is on the outputs, drive the next inputs,
    // advance the model, then wait for the next falling edge.
    task automatic cyc(input int x, input int y, input bit en, input bit rstN);
        bit hX, hY, cnd;
        if (pipeV1) checkVal("pix", {vgaRed, vgaGreen, vgaBlue}, pipe1);
        checkVal("tick", frameTick, tickExp);
        pipe1  = pipe0;
        pipeV1 = pipeV0;
        screenX = x[9:0];
        screenY = y[9:0];
        enable  = en;
        reset   = rstN;
        if (!rstN) begin
            pipe1 = '0; pipeV1 = 1'b1;
            pipe0 = '0; pipeV0 = 1'b1;
            tickExp = 1'b0;
            modelReset();
        end else begin
            cnd = (x == 0 && y == V);
            pipe0 = expColour(x, y);
            pipeV0 = 1'b1;
            tickExp = cnd && !prevCond;
            if (tickExp && en) begin
                moveAxis(bx, dx, H - BOX, hX);
                moveAxis(by, dy, V - BOX, hY);
                if (hX || hY) hc = (hc + 1) % 4;
            end
            prevCond = cnd;
        end
        @(negedge pixelClk);
    endtask

    task automatic doTick(input int hold, input bit en);
        for (int i = 0; i < hold; i++) cyc(0, V, en, 1'b1);
        cyc(5, 5, en, 1'b1);
    endtask

    // Random probes, mostly around the box edges.
    task automatic probe(input int n, input bit en);
        int x, y;
        for (int i = 0; i < n; i++) begin
            if ($urandom_range(0, 2) != 0) begin
                x = bx - 1 + int'($urandom_range(0, BOX + 1));
                y = by - 1 + int'($urandom_range(0, BOX + 1));
                if (x < 0) x = 0;
                if (y < 0) y = 0;
            end else begin
                x = int'($urandom_range(0, 799));
                y = int'($urandom_range(0, 524));
            end
            if (x == 0 && y == V) x = 1;
            cyc(x, y, en, 1'b1);
        end
    endtask

    initial begin
        pal[0] = 24'hFFFFFF;
        pal[1] = 24'hFF2020;
        pal[2] = 24'h20FF20;
        pal[3] = 24'h2020FF;
        pipe0 = '0; pipe1 = '0; pipeV0 = 1'b0; pipeV1 = 1'b0; tickExp = 1'b0;
        modelReset();
        reset = 1'b0; enable = 1'b1; screenX = '0; screenY = '0;
        @(negedge pixelClk);

        // Reset and first pixels
        for (int i = 0; i < 3; i++) cyc(288, 208, 1'b1, 1'b0);
        cyc(288, 208, 1'b1, 1'b1);
        cyc(287, 208, 1'b1, 1'b1);
        cyc(300, 220, 1'b1, 1'b1);
        cyc(650, 10, 1'b1, 1'b1);
        cyc(10, 500, 1'b1, 1'b1);

        // First tick, held for 5 cycles
        doTick(5, 1'b1);
        cyc(289, 209, 1'b1, 1'b1);
        cyc(290, 210, 1'b1, 1'b1);
        probe(4, 1'b1);

        // Run to the first Y bounce (104 ticks total), then X bounce at 144
        for (int t = 2; t <= 145; t++) begin
            doTick(2, 1'b1);
            cyc(bx, by, 1'b1, 1'b1);
            if (t == 104 || t == 144 || t == 145) begin
                cyc(bx + BOX - 1, by + BOX - 1, 1'b1, 1'b1);
                cyc(bx + BOX, by, 1'b1, 1'b1);
                cyc(bx - 1, by, 1'b1, 1'b1);
                probe(6, 1'b1);
            end else begin
                probe(2, 1'b1);
            end
        end

        // Freeze
        for (int t = 0; t < 10; t++) begin
            doTick(3, 1'b0);
            probe(3, 1'b0);
        end
        for (int t = 0; t < 5; t++) begin
            doTick(2, 1'b1);
            probe(3, 1'b1);
        end

        // Mid-frame reset after 50 more ticks
        for (int t = 0; t < 50; t++) begin
            doTick(1, 1'b1);
            probe(2, 1'b1);
        end
        cyc(400, 300, 1'b1, 1'b0);
        cyc(288, 208, 1'b1, 1'b1);
        cyc(287, 208, 1'b1, 1'b1);
        probe(10, 1'b1);
        doTick(2, 1'b1);
        probe(10, 1'b1);
        cyc(5, 5, 1'b1, 1'b1);
        cyc(5, 5, 1'b1, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
